// File: rtl/fetch_pkg.sv
// Shared fetch/control constants: next-PC select codes, bubble word,
// and fetch FSM state encoding.
package fetch_pkg;

   localparam int PC_SEL_WIDTH = 2;

   localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_FOUR   = 2'd0;
   localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_BRANCH = 2'd1;
   localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JAL    = 2'd2;
   localparam logic [PC_SEL_WIDTH-1:0] PC_SEL_JALR   = 2'd3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_REQ,
      FETCH_WAIT
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for a fetched word that arrives while
// decode is stalled.
module fetch_skid_buf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        drain,
   input  logic        clear,
   input  logic [31:0] data_in,
   input  logic [31:0] pc_in,
   output logic        full,
   output logic [31:0] data,
   output logic [31:0] pc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full <= 1'b0;
         data <= '0;
         pc   <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (load) begin
         full <= 1'b1;
         data <= data_in;
         pc   <= pc_in;
      end else if (drain) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding request/grant/rvalid port,
// redirect with discard of in-flight data, and a skid slot for stalls.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [PC_SEL_WIDTH-1:0] pc_sel,
   input  logic [31:0]             branch_target,
   input  logic [31:0]             jal_target,
   input  logic [31:0]             jalr_target,
   input  logic                    stall_if,
   input  logic                    flush_if,
   output logic                    imem_req,
   output logic [31:0]             imem_addr,
   input  logic                    imem_gnt,
   input  logic                    imem_rvalid,
   input  logic [31:0]             imem_rdata,
   output logic [31:0]             instr_decode,
   output logic [31:0]             pc_decode,
   output logic                    valid_decode
);

   fetch_state_e state, state_nx;
   logic         discard, discard_nx;
   logic [31:0]  fetch_pc, req_pc, target;
   logic         redirect, gnt_fire, resp, accept;
   logic         to_ifid, to_buf, drain;
   logic         buf_full;
   logic [31:0]  buf_data, buf_pc;

   always_comb begin
      target = branch_target;
      unique case (1'b1)
         (pc_sel == PC_SEL_JAL):  target = jal_target;
         (pc_sel == PC_SEL_JALR): target = jalr_target;
         default:                 target = branch_target;
      endcase
   end

   // Stall always wins over a redirect; control re-presents it later.
   assign redirect = (pc_sel != PC_SEL_FOUR) && !stall_if;
   assign imem_req  = (state == FETCH_REQ);
   assign imem_addr = fetch_pc;
   assign gnt_fire  = imem_req && imem_gnt;
   assign resp      = (state == FETCH_WAIT) && imem_rvalid;
   assign accept    = resp && !discard && !redirect;
   assign to_ifid   = accept && !stall_if;
   assign to_buf    = accept && stall_if;
   assign drain     = buf_full && !stall_if && !redirect;

   always_comb begin
      state_nx   = state;
      discard_nx = discard;
      unique case (state)
         FETCH_IDLE: begin
            if (!buf_full || redirect) state_nx = FETCH_REQ;
         end
         FETCH_REQ: begin
            if (gnt_fire) begin
               state_nx   = FETCH_WAIT;
               discard_nx = redirect;
            end
         end
         FETCH_WAIT: begin
            if (resp) begin
               discard_nx = 1'b0;
               state_nx   = to_buf ? FETCH_IDLE : FETCH_REQ;
            end else if (redirect) begin
               discard_nx = 1'b1;
            end
         end
         default: state_nx = FETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= FETCH_IDLE;
         discard  <= 1'b0;
         fetch_pc <= word_align(RESET_PC);
         req_pc   <= '0;
      end else begin
         state   <= state_nx;
         discard <= discard_nx;
         if (redirect)
            fetch_pc <= word_align(target);
         else if (gnt_fire)
            fetch_pc <= fetch_pc + 32'd4;
         if (gnt_fire)
            req_pc <= fetch_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_decode <= NOP_INSTR;
         pc_decode    <= '0;
         valid_decode <= 1'b0;
      end else if (!stall_if) begin
         if (redirect) begin
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
         end else if (drain) begin
            instr_decode <= buf_data;
            pc_decode    <= buf_pc;
            valid_decode <= 1'b1;
         end else if (to_ifid) begin
            instr_decode <= imem_rdata;
            pc_decode    <= req_pc;
            valid_decode <= 1'b1;
         end else if (flush_if) begin
            instr_decode <= NOP_INSTR;
            valid_decode <= 1'b0;
         end
      end
   end

   fetch_skid_buf u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (to_buf),
      .drain   (drain),
      .clear   (redirect),
      .data_in (imem_rdata),
      .pc_in   (req_pc),
      .full    (buf_full),
      .data    (buf_data),
      .pc      (buf_pc)
   );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0): bubble inserted into IF/ID.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 pc_sel  in  PC_SEL_WIDTH  next-PC source from control: PC_SEL_FOUR, PC_SEL_BRANCH, PC_SEL_JAL, PC_SEL_JALR.
REQ-006 branch_target, jal_target, jalr_target  in  32 each  redirect addresses computed in decode.
REQ-007 stall_if  in  1  hold IF/ID contents and fetch PC.
REQ-008 flush_if  in  1  squash the IF/ID contents (asserted with every redirect).
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  32  word-aligned fetch address, stable while imem_req high.
REQ-011 imem_gnt  in  1  request accepted this cycle.
REQ-012 imem_rvalid  in  1  read data valid; at least one cycle after gnt, in order.
REQ-013 imem_rdata  in  32  instruction word.
REQ-014 instr_decode  out  32  IF/ID instruction register.
REQ-015 pc_decode  out  32  IF/ID PC register.
REQ-016 valid_decode  out  1  IF/ID holds a real instruction.

Function
REQ-017 FSM states: IDLE (no request), REQ (imem_req=1, awaiting gnt), WAIT (granted, awaiting rvalid); at most one outstanding request.
REQ-018 IDLE->REQ whenever the skid buffer is empty; REQ->WAIT on imem_gnt; WAIT->REQ on imem_rvalid if the buffer stays empty after the response, else WAIT->IDLE.
REQ-019 imem_addr = fetch_pc; on gnt, fetch_pc <= fetch_pc + 4 (modulo 2^32, wrap without error).
REQ-020 Response with stall_if=0 and no discard pending: instr_decode<=imem_rdata, pc_decode<=address of that request, valid_decode<=1, same edge.
REQ-021 Response with stall_if=1: word and its PC captured in a 1-entry skid buffer; IF/ID unchanged; no new request while buffer full.
REQ-022 stall_if falling with buffer full: IF/ID loads from buffer on the next edge with stall_if=0; buffer empties; fetching resumes next cycle.
REQ-023 stall_if=1 with no response: IF/ID, fetch_pc and FSM request state hold; a REQ already presented stays presented.
REQ-024 Redirect = pc_sel != PC_SEL_FOUR with stall_if=0: fetch_pc <= selected target, IF/ID <= {NOP_INSTR, target-irrelevant PC, valid 0}, skid buffer cleared.
REQ-025 Redirect in WAIT: set discard flag; the next imem_rvalid is dropped (no IF/ID or buffer update), flag clears, FSM -> REQ at the target.
REQ-026 Redirect in REQ before gnt: imem_addr switches to target next cycle; the old request is withdrawn (memory samples only on gnt).
REQ-027 Redirect and imem_gnt same cycle: treated as granted then squashed -> WAIT with discard set; fetch_pc <= target.
REQ-028 stall_if=1 and redirect together: stall wins; redirect ignored (control reasserts it once the stalled branch proceeds).
REQ-029 flush_if=1 with pc_sel=PC_SEL_FOUR: IF/ID bubbled, fetch_pc unaffected.
REQ-030 Misaligned target (bits[1:0]!=0): bits[1:0] forced to 0 on imem_addr.

Reset
REQ-031 rst_n low, asynchronously: fetch_pc=RESET_PC, FSM=IDLE, imem_req=0, discard=0, buffer empty, instr_decode=NOP_INSTR, pc_decode=0, valid_decode=0.
REQ-032 Reset mid-request: outstanding response after rst_n release is not accepted unless a new grant occurred; memory side is also reset.
REQ-033 First imem_req asserted the cycle after rst_n deasserts.

Structure
REQ-034 PC_SEL_* codes, PC_SEL_WIDTH, NOP_INSTR and fetch FSM state enum reside in the shared constants package used by control.
REQ-035 Skid buffer is a separate sub-module fetch_skid_buf (1-entry, data+PC, full flag, load/drain/clear).

Verification
REQ-036 Reset, gnt same cycle, rvalid 1 cycle later, 4 fetches -> pc_decode 0,4,8,12, valid_decode=1 each, instr matching rdata.
REQ-037 rvalid arrives with stall_if=1 for 3 cycles -> IF/ID unchanged, imem_req=0, word appears in IF/ID the edge after stall drops.
REQ-038 In WAIT, pc_sel=PC_SEL_BRANCH, branch_target=0x100, flush_if=1 -> IF/ID=NOP valid 0; pending rdata dropped; next imem_addr=0x100.
REQ-039 pc_sel=PC_SEL_JAL coincident with imem_gnt -> response discarded, next grant address = jal_target.
REQ-040 stall_if=1 and pc_sel=PC_SEL_JALR together -> fetch_pc and IF/ID unchanged; redirect taken when reasserted without stall.
REQ-041 fetch_pc=0xFFFF_FFFC granted -> next imem_addr=0x0000_0000; rst_n pulsed in WAIT -> all outputs at reset values asynchronously.
